// File: rtl/axis_write_data_pkg.sv
// Shared definitions for the AXI write-data engine: one-hot FSM encoding,
// beat-count arithmetic and strobe sizing.
package axis_write_data_pkg;

  localparam int unsigned NUM_STATES = 3;
  localparam int unsigned S_CONFIG   = 0;
  localparam int unsigned S_ACTIVE   = 1;
  localparam int unsigned S_DRAIN    = 2;

  typedef logic [NUM_STATES-1:0] state_t;

  localparam state_t ST_CONFIG = state_t'(1 << S_CONFIG);
  localparam state_t ST_ACTIVE = state_t'(1 << S_ACTIVE);
  localparam state_t ST_DRAIN  = state_t'(1 << S_DRAIN);

  localparam int unsigned AXI_DATA_WIDTH_DFLT = 64;
  localparam int unsigned STRB_WIDTH          = AXI_DATA_WIDTH_DFLT / 8;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Written as quotient plus remainder test so that lengths near the top of
  // the counter range never overflow.
  function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
    return (num / den) + (((num % den) != 64'd0) ? 64'd1 : 64'd0);
  endfunction

endpackage

// File: rtl/axis_write_data_if.sv
// Config, narrow stream and AXI write-data bundle for axis_write_data.
// master = the engine, slave = its environment.
interface axis_write_data_if #(
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [CFG_DWIDTH-1:0]     cfg_length;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [DATA_WIDTH-1:0]     data;
  logic                      valid;
  logic                      ready;
  logic [AXI_DATA_WIDTH-1:0] axi_wdata;
  logic [STRB_W-1:0]         axi_wstrb;
  logic                      axi_wlast;
  logic                      axi_wvalid;
  logic                      axi_wready;

  modport master (
    input  cfg_length, cfg_valid, data, valid, axi_wready,
    output cfg_ready, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
  );

  modport slave (
    output cfg_length, cfg_valid, data, valid, axi_wready,
    input  cfg_ready, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
  );

endinterface

// File: rtl/axis_deserializer.sv
// Packs DATA_NB narrow words into one wide word, lane 0 in the LSBs. The wide
// word is presented in the same cycle its last word is accepted; flush closes
// a short word early with the unused lanes zeroed and their keep bits clear.
module axis_deserializer #(
  parameter int unsigned DATA_NB    = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic                          flush,
  output logic [DATA_NB*DATA_WIDTH-1:0] down_data,
  output logic [DATA_NB-1:0]            down_keep,
  output logic                          down_valid,
  input  logic                          down_ready
);
  localparam int unsigned LW = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;

  logic [LW-1:0]                 lane_q;
  logic [DATA_NB*DATA_WIDTH-1:0] hold_q;
  logic                          last_lane_c;

  assign last_lane_c = (lane_q == LW'(DATA_NB - 1));
  assign up_ready    = down_ready;
  assign down_valid  = up_valid & (last_lane_c | flush);

  // Earlier lanes come from the holding register, the current lane straight
  // from the input, later lanes are zero.
  always_comb begin
    down_data = '0;
    down_keep = '0;
    for (int i = 0; i < DATA_NB; i++) begin
      if (LW'(i) < lane_q) begin
        down_data[i*DATA_WIDTH +: DATA_WIDTH] = hold_q[i*DATA_WIDTH +: DATA_WIDTH];
        down_keep[i] = 1'b1;
      end else if (LW'(i) == lane_q) begin
        down_data[i*DATA_WIDTH +: DATA_WIDTH] = up_data;
        down_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      hold_q <= '0;
    end else if (up_valid && up_ready) begin
      if (down_valid) begin
        lane_q <= '0;
      end else begin
        hold_q[lane_q*DATA_WIDTH +: DATA_WIDTH] <= up_data;
        lane_q <= lane_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_simple.sv
// Plain synchronous FIFO with registered pointers, asynchronous read port
// and an almost-full flag AFULL_MARGIN entries below full.
module fifo_simple #(
  parameter int unsigned WIDTH        = 72,
  parameter int unsigned AWIDTH       = 9,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             afull,
  output logic             empty
);
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q;
  logic [AWIDTH-1:0] rd_ptr_q;
  logic [AWIDTH:0]   count_q;
  logic              full;
  logic              push_c;
  logic              pop_c;

  assign full    = (count_q == (AWIDTH+1)'(DEPTH));
  assign afull   = (count_q >= (AWIDTH+1)'(DEPTH - AFULL_MARGIN));
  assign empty   = (count_q == '0);
  assign push_c  = wr_en & ~full;
  assign pop_c   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_c)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_write_data.sv
// AXI write-data engine: packs a narrow stream into AXI beats, buffers them and
// frames wlast per burst. `define AXIS_WRITE_DATA_PARTIAL_EN for short-beat strobes.
module axis_write_data
  import axis_write_data_pkg::*;
#(
  parameter int unsigned BUF_AWIDTH     = 9,
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned WIDTH_RATIO    = 2,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BURST_LEN      = 16
) (
  input logic               clk,
  input logic               rst,
  axis_write_data_if.master bus
);
  localparam int unsigned STRB_W     = strb_width(AXI_DATA_WIDTH);
  localparam int unsigned LANE_BYTES = strb_width(DATA_WIDTH);
  localparam int unsigned FIFO_W     = STRB_W + AXI_DATA_WIDTH;

  state_t state_q;
  state_t state_d;

  logic [CFG_DWIDTH-1:0] len_q;
  logic [CFG_DWIDTH-1:0] beats_q;
  logic [CFG_DWIDTH-1:0] word_cnt_q;
  logic [CFG_DWIDTH-1:0] beat_cnt_q;
  logic [CFG_DWIDTH-1:0] burst_cnt_q;

  logic cfg_ready_c;
  logic active_c;
  logic cfg_accept_c;
  logic words_left_c;
  logic final_word_c;
  logic up_valid_c;
  logic des_up_ready;
  logic accept_c;
  logic last_beat_c;
  logic burst_end_c;
  logic hs_c;
  logic load_c;

  logic [AXI_DATA_WIDTH-1:0] pk_data;
  logic [WIDTH_RATIO-1:0]    pk_keep;
  logic [STRB_W-1:0]         pk_strb;
  logic                      push_c;

  logic [FIFO_W-1:0] fifo_rd_data;
  logic              buf_afull;
  logic              fifo_empty;

  logic [AXI_DATA_WIDTH-1:0] out_data_q;
  logic [STRB_W-1:0]         out_strb_q;
  logic                      out_valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CONFIG;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q[S_CONFIG]) begin
      if (bus.cfg_valid) state_d = (bus.cfg_length == '0) ? ST_DRAIN : ST_ACTIVE;
    end else if (state_q[S_ACTIVE]) begin
      if (accept_c && final_word_c) state_d = ST_DRAIN;
    end else if (state_q[S_DRAIN]) begin
      if ((beats_q == '0) || (hs_c && last_beat_c)) state_d = ST_CONFIG;
    end else begin
      state_d = ST_CONFIG;
    end
  end

  // State decode
  always_comb begin
    cfg_ready_c = state_q[S_CONFIG];
    active_c    = state_q[S_ACTIVE];
  end

  assign cfg_accept_c = cfg_ready_c & bus.cfg_valid;
  assign words_left_c = (word_cnt_q < len_q);
  assign final_word_c = (word_cnt_q == len_q - 1'b1);
  assign up_valid_c   = active_c & words_left_c & bus.valid;
  assign accept_c     = up_valid_c & des_up_ready;
  assign hs_c         = out_valid_q & bus.axi_wready;
  assign last_beat_c  = (beat_cnt_q == beats_q - 1'b1);
  assign burst_end_c  = (burst_cnt_q == CFG_DWIDTH'(BURST_LEN - 1));

  assign bus.cfg_ready  = cfg_ready_c;
  assign bus.ready      = active_c & words_left_c & des_up_ready;
  assign bus.axi_wdata  = out_data_q;
  assign bus.axi_wstrb  = out_strb_q;
  assign bus.axi_wvalid = out_valid_q;
  assign bus.axi_wlast  = out_valid_q & (burst_end_c | last_beat_c);

  axis_deserializer #(
    .DATA_NB    (WIDTH_RATIO),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .up_data    (bus.data),
    .up_valid   (up_valid_c),
    .up_ready   (des_up_ready),
    .flush      (final_word_c),
    .down_data  (pk_data),
    .down_keep  (pk_keep),
    .down_valid (push_c),
    .down_ready (~buf_afull)
  );

`ifdef AXIS_WRITE_DATA_PARTIAL_EN
  // Each lane's bytes follow that lane's keep bit.
  always_comb begin
    pk_strb = '0;
    for (int i = 0; i < WIDTH_RATIO; i++) begin
      pk_strb[i*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{pk_keep[i]}};
    end
  end
`else
  assign pk_strb = '1;
  logic unused_keep;
  assign unused_keep = ^pk_keep;
`ifdef VERBOSE
  always_ff @(posedge clk) begin
    if (!rst && cfg_accept_c && ((bus.cfg_length % CFG_DWIDTH'(WIDTH_RATIO)) != '0))
      $warning("axis_write_data: length %0d not a multiple of %0d, final beat fully strobed",
               bus.cfg_length, WIDTH_RATIO);
  end
`endif
`endif

  fifo_simple #(
    .WIDTH        (FIFO_W),
    .AWIDTH       (BUF_AWIDTH),
    .AFULL_MARGIN (2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_c),
    .wr_data ({pk_strb, pk_data}),
    .rd_en   (load_c),
    .rd_data (fifo_rd_data),
    .afull   (buf_afull),
    .empty   (fifo_empty)
  );

  // Output stage refills only when empty or handshaking, so a stalled beat holds.
  assign load_c = ~fifo_empty & (~out_valid_q | bus.axi_wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else if (load_c) begin
      out_valid_q <= 1'b1;
      {out_strb_q, out_data_q} <= fifo_rd_data;
    end else if (hs_c) begin
      out_valid_q <= 1'b0;
    end
  end

  // Transfer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      beats_q     <= '0;
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else if (cfg_accept_c) begin
      len_q       <= bus.cfg_length;
      beats_q     <= CFG_DWIDTH'(ceil_div(64'(bus.cfg_length), 64'(WIDTH_RATIO)));
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (accept_c) word_cnt_q <= word_cnt_q + 1'b1;
      if (hs_c) begin
        beat_cnt_q  <= beat_cnt_q + 1'b1;
        burst_cnt_q <= burst_end_c ? '0 : burst_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_write_data.md
Name: axis_write_data

Overview:
AXI write-data channel engine; the transmit-side counterpart of the read-data path. Accepts a narrow stream (DATA_WIDTH), packs WIDTH_RATIO words per AXI beat, buffers the beats in a FIFO, and drives axi_wdata/wstrb/wlast/wvalid. The transfer length arrives per transaction on a cfg handshake. wlast is framed to match the burst split issued by the write-address engine.

Parameters:
BUF_AWIDTH, 9, log2 depth of the beat FIFO
CFG_DWIDTH, 32, width of cfg_length
WIDTH_RATIO, 2, stream words per AXI beat; AXI_DATA_WIDTH = WIDTH_RATIO*DATA_WIDTH
AXI_DATA_WIDTH, 64, AXI write data width
DATA_WIDTH, 32, stream word width
BURST_LEN, 16, maximum beats per AXI burst; wlast framing period

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_length  in  CFG_DWIDTH  stream words in the transfer
cfg_valid  in  1  config handshake valid
cfg_ready  out  1  high in CONFIG state
data  in  DATA_WIDTH  stream data
valid  in  1  stream valid
ready  out  1  stream ready
axi_wdata  out  AXI_DATA_WIDTH  write data
axi_wstrb  out  AXI_DATA_WIDTH/8  byte strobes
axi_wlast  out  1  last beat of burst
axi_wvalid  out  1  write valid
axi_wready  in  1  write ready

Behaviour:
- One clock: clk. Reset rst is synchronous and active-high.
- Reset: state=CONFIG, cfg_ready=1, ready=0, axi_wvalid=0, axi_wlast=0, FIFO empty, all counters 0.
- One-hot FSM with states CONFIG, ACTIVE, DRAIN.
- CONFIG:
  - On cfg_valid, latch len=cfg_length and beats=ceil(len/WIDTH_RATIO); clear counters.
  - Go to ACTIVE, or to DRAIN if cfg_length=0; with length 0 the FSM returns to CONFIG on the next cycle and no beats are emitted.
- ACTIVE:
  - ready = ~buf_afull & (word_cnt < len).
  - Each valid&ready fills the next lane of the packing register. Lane 0 is the LSBs (first word at [DATA_WIDTH-1:0]).
  - On the lane WIDTH_RATIO-1 or on the final word (word_cnt==len-1), the packed beat and its strobe are pushed to the FIFO in the same cycle.
  - After the final word is accepted, go to DRAIN; ready=0 from then on.
- DRAIN: when the final beat handshakes (axi_wvalid & axi_wready & beat_cnt==beats-1), go to CONFIG. cfg_ready rises on the next cycle.
- AXI side:
  - FIFO read uses first-word-fall-through registering; axi_wvalid = output register valid.
  - Data and strobe are held stable while axi_wvalid & ~axi_wready (AXI rule; wvalid never drops without a handshake).
  - Latency: first stream word to axi_wvalid is at most WIDTH_RATIO+2 cycles at full rate.
- wlast:
  - burst_cnt counts handshaked beats modulo BURST_LEN.
  - axi_wlast=1 when burst_cnt==BURST_LEN-1 or beat_cnt==beats-1.
  - Both counters advance only on handshake.
- Arithmetic: counters are CFG_DWIDTH wide. Lengths up to 2^CFG_DWIDTH-1 are legal; no wrap within a transfer.
- FIFO full: axi_wready stall back-pressures to ready=0 via buf_afull. No beat is lost or duplicated.
- Simultaneous push and pop of the FIFO in one cycle is legal.
- cfg_valid outside CONFIG is ignored.
- rst mid-transfer: the packed partial beat and FIFO contents are discarded, axi_wvalid drops next cycle, and the FSM returns to CONFIG. The system must also reset the AXI slave side.

Optional Feature:
AXIS_WRITE_DATA_PARTIAL_EN
- Defined: a final beat with fewer than WIDTH_RATIO words has unused lanes zeroed, and axi_wstrb clears the bytes of those lanes. All other beats use full strobes.
- Undefined: cfg_length must be a multiple of WIDTH_RATIO and axi_wstrb is constant all-ones.
  - A non-multiple length still zero-pads the final beat but writes all bytes.
  - In simulation, `VERBOSE prints a warning.

Decomposition:
- Shared package: FSM state indices (CONFIG=0, ACTIVE=1, DRAIN=2), the ceil-divide beat-count function, and the strobe-width constant AXI_DATA_WIDTH/8.
- Sub-module axis_deserializer, the inverse of axis_serializer: DATA_NB, DATA_WIDTH, up/down valid-ready, plus a flush input for the partial final beat.
- The FIFO reuses fifo_simple.

Test Plan:
- len=4, WIDTH_RATIO=2, words 0x1..0x4, wready=1 -> 2 beats: 0x00000002_00000001 then 0x00000004_00000003; wlast on beat 2; cfg_ready returns 1.
- len=40, BURST_LEN=16 -> 20 beats; wlast on beats 16 and 20 only.
- len=5 with PARTIAL_EN -> beat 3 = 0x00000000_00000005, wstrb=0x0F. Without the macro -> same data, wstrb=0xFF.
- wready held 0 for 600 cycles, len=2000 -> ready drops at almost-full; no beat lost or reordered; wdata is stable during stall.
- cfg_length=0 -> no wvalid; cfg_ready is high again within 2 cycles.
- rst asserted after 3 of 8 beats -> wvalid=0 next cycle. A new len=2 transfer then emits exactly 1 correct beat.
